// File: rtl/core_v_mcu_pkg.sv
// Shared MCU definitions: register-interface structs, bus slave indices and
// the machine-timer base address and register offsets.
package core_v_mcu_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef enum int unsigned {
    SOC_CTRL_REG_IDX       = 0,
    FAST_INTR_CTRL_REG_IDX = 1,
    MTIMER_REG_IDX         = 2
  } reg_slave_idx_e;

  localparam int unsigned NumRegSlaves = 3;

  localparam logic [31:0] MTIMER_START_ADDRESS = 32'h2003_0000;
  localparam logic [31:0] MTIMER_SIZE          = 32'h0000_0020;
  localparam logic [31:0] MTIMER_END_ADDRESS   = MTIMER_START_ADDRESS + MTIMER_SIZE;

  typedef enum logic [4:0] {
    MTIMER_CTRL_OFFSET     = 5'h00,
    MTIMER_PRESC_OFFSET    = 5'h04,
    MTIMER_MTIME_LO_OFFSET = 5'h08,
    MTIMER_MTIME_HI_OFFSET = 5'h0C,
    MTIMER_CMP_LO_OFFSET   = 5'h10,
    MTIMER_CMP_HI_OFFSET   = 5'h14,
    MTIMER_STATUS_OFFSET   = 5'h18,
    MTIMER_RSVD_OFFSET     = 5'h1C
  } mtimer_reg_offset_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Reloading prescaler for the machine timer: emits a one-cycle tick each time
// the counter reaches the reload value while enabled.
module mtimer_prescaler #(
  parameter int unsigned PrescWidth = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_en,
  input  logic [PrescWidth-1:0] i_reload,
  input  logic                  i_clr,
  output logic                  o_tick
);

  logic [PrescWidth-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == i_reload);

  // A clear wins over counting; the tick of the current cycle is still reported.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + PrescWidth'(1);
    end
  end

endmodule

// File: rtl/mtimer_ctrl.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on a register-interface slave,
// with a registered level timer interrupt.
module mtimer_ctrl #(
  parameter type         reg_req_t  = core_v_mcu_pkg::reg_req_t,
  parameter type         reg_rsp_t  = core_v_mcu_pkg::reg_rsp_t,
  parameter int unsigned PrescWidth = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  reg_req_t    reg_req_i,
  output reg_rsp_t    reg_rsp_o,
  output logic        time_irq_o,
  output logic [63:0] mtime_o
);

  import core_v_mcu_pkg::*;

  logic                  r_en;
  logic                  r_irq_en;
  logic [PrescWidth-1:0] r_presc;
  logic [63:0]           r_mtime;
  logic [63:0]           r_cmp;
  logic [31:0]           r_hi_shadow;
  logic                  r_irq;

  logic [4:0]  w_off;
  logic        w_addr_ok;
  logic        w_wr;
  logic        w_rd;
  logic        w_tick;
  logic        w_presc_clr;
  logic        w_match;
  logic [1:0]  w_ctrl_new;
  logic        w_unused;

  assign w_off     = {reg_req_i.addr[4:2], 2'b00};
  assign w_addr_ok = (reg_req_i.addr[31:5] == '0) && (w_off != MTIMER_RSVD_OFFSET);
  assign w_wr      = reg_req_i.valid && reg_req_i.write && w_addr_ok;
  assign w_rd      = reg_req_i.valid && !reg_req_i.write && w_addr_ok;
  assign w_match   = (r_mtime >= r_cmp);
  assign w_unused  = ^reg_req_i.addr[1:0];

  assign w_ctrl_new = 2'(apply_wstrb({30'b0, r_irq_en, r_en}, reg_req_i.wdata, reg_req_i.wstrb));

  // Any write that repositions the count restarts the prescaler phase.
  assign w_presc_clr = w_wr && ((w_off == MTIMER_PRESC_OFFSET) ||
                                (w_off == MTIMER_MTIME_LO_OFFSET) ||
                                (w_off == MTIMER_MTIME_HI_OFFSET));

  mtimer_prescaler #(
    .PrescWidth(PrescWidth)
  ) u_presc (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_en    (r_en),
    .i_reload(r_presc),
    .i_clr   (w_presc_clr),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_presc  <= '0;
      r_cmp    <= '1;
    end else if (w_wr) begin
      case (w_off)
        MTIMER_CTRL_OFFSET:   {r_irq_en, r_en} <= w_ctrl_new;
        MTIMER_PRESC_OFFSET:  r_presc <= PrescWidth'(apply_wstrb(32'(r_presc), reg_req_i.wdata,
                                                                 reg_req_i.wstrb));
        MTIMER_CMP_LO_OFFSET: r_cmp[31:0] <= apply_wstrb(r_cmp[31:0], reg_req_i.wdata,
                                                         reg_req_i.wstrb);
        MTIMER_CMP_HI_OFFSET: r_cmp[63:32] <= apply_wstrb(r_cmp[63:32], reg_req_i.wdata,
                                                          reg_req_i.wstrb);
        default: ;
      endcase
    end
  end

  // A bus write to either mtime half beats a concurrent tick, which is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mtime <= '0;
    end else if (w_wr && (w_off == MTIMER_MTIME_LO_OFFSET)) begin
      r_mtime[31:0] <= apply_wstrb(r_mtime[31:0], reg_req_i.wdata, reg_req_i.wstrb);
    end else if (w_wr && (w_off == MTIMER_MTIME_HI_OFFSET)) begin
      r_mtime[63:32] <= apply_wstrb(r_mtime[63:32], reg_req_i.wdata, reg_req_i.wstrb);
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hi_shadow <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_rd && (w_off == MTIMER_MTIME_LO_OFFSET)) r_hi_shadow <= r_mtime[63:32];
      r_irq <= r_irq_en && w_match;
    end
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = reg_req_i.valid && !w_addr_ok;
    if (w_rd) begin
      case (w_off)
        MTIMER_CTRL_OFFSET:     reg_rsp_o.rdata = {30'b0, r_irq_en, r_en};
        MTIMER_PRESC_OFFSET:    reg_rsp_o.rdata = 32'(r_presc);
        MTIMER_MTIME_LO_OFFSET: reg_rsp_o.rdata = r_mtime[31:0];
        MTIMER_MTIME_HI_OFFSET: reg_rsp_o.rdata = r_hi_shadow;
        MTIMER_CMP_LO_OFFSET:   reg_rsp_o.rdata = r_cmp[31:0];
        MTIMER_CMP_HI_OFFSET:   reg_rsp_o.rdata = r_cmp[63:32];
        MTIMER_STATUS_OFFSET:   reg_rsp_o.rdata = {31'b0, w_match};
        default:                reg_rsp_o.rdata = '0;
      endcase
    end
  end

  assign time_irq_o = r_irq;
  assign mtime_o    = r_mtime;

endmodule

// File: tb/tb_mtimer_ctrl.sv
// Self-checking bench for mtimer_ctrl: directed scenarios plus a randomized
// bus phase, all compared against a register-level reference model.
module tb_mtimer_ctrl;

  import core_v_mcu_pkg::*;

  logic        clk_i;
  logic        rst_i;
  reg_req_t    req;
  reg_rsp_t    rsp;
  logic        time_irq_o;
  logic [63:0] mtime_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic        m_en, m_irq_en, m_irq;
  logic [15:0] m_presc, m_cnt;
  logic [63:0] m_mtime, m_cmp;
  logic [31:0] m_shadow;

  mtimer_ctrl #(
    .reg_req_t (reg_req_t),
    .reg_rsp_t (reg_rsp_t),
    .PrescWidth(16)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .reg_req_i (req),
    .reg_rsp_o (rsp),
    .time_irq_o(time_irq_o),
    .mtime_o   (mtime_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (d & mask);
  endfunction

  task automatic model_reset();
    m_en = 0; m_irq_en = 0; m_irq = 0;
    m_presc = 0; m_cnt = 0;
    m_mtime = 0; m_cmp = '1; m_shadow = 0;
  endtask

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[31:5] == 27'd0) && (a[4:2] != 3'd7);
  endfunction

  task automatic model_rsp(input logic v, input logic w, input logic [31:0] a,
                           output logic [31:0] rdata, output logic err);
    err   = v && !addr_ok(a);
    rdata = 32'd0;
    if (v && !w && addr_ok(a)) begin
      case (a[4:2])
        3'd0: rdata = {30'd0, m_irq_en, m_en};
        3'd1: rdata = {16'd0, m_presc};
        3'd2: rdata = m_mtime[31:0];
        3'd3: rdata = m_shadow;
        3'd4: rdata = m_cmp[31:0];
        3'd5: rdata = m_cmp[63:32];
        3'd6: rdata = {31'd0, (m_mtime >= m_cmp)};
        default: rdata = 32'd0;
      endcase
    end
  endtask

  // One clock of the timer as seen by software: count, interrupt, then bus effects.
  task automatic model_step(input logic v, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
    logic        wr, tick;
    logic [63:0] n_mtime;
    logic [15:0] n_cnt;
    logic [31:0] tmp;
    wr      = v && w && addr_ok(a);
    tick    = m_en && (m_cnt == m_presc);
    m_irq   = m_irq_en && (m_mtime >= m_cmp);
    n_mtime = tick ? m_mtime + 64'd1 : m_mtime;
    n_cnt   = !m_en ? m_cnt : (tick ? 16'd0 : m_cnt + 16'd1);
    if (v && !w && addr_ok(a) && a[4:2] == 3'd2) m_shadow = m_mtime[63:32];
    if (wr) begin
      case (a[4:2])
        3'd0: begin
          tmp = merge({30'd0, m_irq_en, m_en}, d, s);
          m_en = tmp[0]; m_irq_en = tmp[1];
        end
        3'd1: begin
          tmp = merge({16'd0, m_presc}, d, s);
          m_presc = tmp[15:0]; n_cnt = 0;
        end
        3'd2: begin n_mtime = {m_mtime[63:32], merge(m_mtime[31:0], d, s)}; n_cnt = 0; end
        3'd3: begin n_mtime = {merge(m_mtime[63:32], d, s), m_mtime[31:0]}; n_cnt = 0; end
        3'd4: m_cmp[31:0]  = merge(m_cmp[31:0], d, s);
        3'd5: m_cmp[63:32] = merge(m_cmp[63:32], d, s);
        default: ;
      endcase
    end
    m_mtime = n_mtime;
    m_cnt   = n_cnt;
  endtask

  // Called just after a rising edge; returns at the next rising edge + 1.
  task automatic step(input logic v, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic er);
    logic [31:0] e_rd;
    logic        e_er;
    req.valid = v; req.write = w; req.addr = a; req.wdata = d; req.wstrb = s;
    @(negedge clk_i);
    model_rsp(v, w, a, e_rd, e_er);
    check("rdata", 64'(rsp.rdata), 64'(e_rd));
    check("error", 64'(rsp.error), 64'(e_er));
    check("ready", 64'(rsp.ready), 64'd1);
    rd = rsp.rdata;
    er = rsp.error;
    @(posedge clk_i);
    model_step(v, w, a, d, s);
    #1;
    req.valid = 1'b0;
    check("mtime", mtime_o, m_mtime);
    check("irq", 64'(time_irq_o), 64'(m_irq));
  endtask

  logic [31:0] g_rd;
  logic        g_er;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, d, 4'hF, g_rd, g_er);
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b1, 1'b0, a, 32'd0, 4'h0, g_rd, g_er);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 4'h0, g_rd, g_er);
  endtask

  initial begin
    logic [63:0] snap;
    logic [31:0] ra, rdat;
    logic [3:0]  rs;
    logic [2:0]  idx;
    logic        rv, rw;
    int          guard;

    req   = '0;
    rst_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_mtime", mtime_o, 64'd0);
    check("reset_irq", 64'(time_irq_o), 64'd0);
    rst_i = 1'b0;

    // Reset values through the bus
    rd(32'h00); check("rst_ctrl", 64'(g_rd), 64'd0);
    rd(32'h04); check("rst_presc", 64'(g_rd), 64'd0);
    rd(32'h08); check("rst_mtime_lo", 64'(g_rd), 64'd0);
    rd(32'h0C); check("rst_mtime_hi", 64'(g_rd), 64'd0);
    rd(32'h10); check("rst_cmp_lo", 64'(g_rd), 64'hFFFF_FFFF);
    rd(32'h14); check("rst_cmp_hi", 64'(g_rd), 64'hFFFF_FFFF);
    rd(32'h1C); check("rsvd_err", 64'(g_er), 64'd1);
    rd(32'h20); check("oob_err", 64'(g_er), 64'd1);
    wr(32'h18, 32'h1); check("status_wr_err", 64'(g_er), 64'd0);

    // Prescaler of 4 cycles per tick, then freeze
    wr(32'h04, 32'd3);
    wr(32'h00, 32'h1);
    idle(40);
    check("presc_40cyc", mtime_o, 64'd10);
    wr(32'h00, 32'h0);
    idle(20);
    check("freeze", mtime_o, 64'd10);

    // 64-bit wrap
    wr(32'h08, 32'hFFFF_FFFE);
    wr(32'h0C, 32'hFFFF_FFFF);
    wr(32'h04, 32'd0);
    wr(32'h00, 32'h1);
    check("wrap_pre", mtime_o, 64'hFFFF_FFFF_FFFF_FFFE);
    idle(1);
    check("wrap_max", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    check("wrap_zero", mtime_o, 64'd0);

    // Tear-free read via the high-half shadow
    wr(32'h00, 32'h0);
    wr(32'h08, 32'hFFFF_FFF0);
    wr(32'h0C, 32'h0);
    wr(32'h00, 32'h1);
    idle(15);
    rd(32'h08); check("lo_at_carry", 64'(g_rd), 64'hFFFF_FFFF);
    idle(4);
    rd(32'h0C); check("hi_shadow", 64'(g_rd), 64'd0);
    check("hi_live", mtime_o[63:32], 64'd1);

    // Compare interrupt rise and fall
    wr(32'h00, 32'h0);
    wr(32'h08, 32'h0);
    wr(32'h0C, 32'h0);
    wr(32'h14, 32'h0);
    wr(32'h10, 32'd100);
    wr(32'h00, 32'h3);
    guard = 0;
    while (mtime_o != 64'd100 && guard < 300) begin
      idle(1);
      guard++;
    end
    check("reach_100", mtime_o, 64'd100);
    check("irq_not_yet", 64'(time_irq_o), 64'd0);
    idle(1);
    check("irq_rise", 64'(time_irq_o), 64'd1);
    wr(32'h14, 32'h1);
    idle(1);
    check("irq_fall", 64'(time_irq_o), 64'd0);

    // Write beats tick, byte strobe on mtime low byte
    wr(32'h00, 32'h1);
    snap = mtime_o;
    step(1'b1, 1'b1, 32'h08, 32'h0000_0055, 4'h1, g_rd, g_er);
    check("collide", mtime_o, {snap[63:8], 8'h55});

    // Asynchronous reset in the middle of a write
    wr(32'h00, 32'h3);
    idle(3);
    req.valid = 1'b1; req.write = 1'b1; req.addr = 32'h10; req.wdata = 32'h0; req.wstrb = 4'hF;
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_async_mtime", mtime_o, 64'd0);
    check("rst_async_irq", 64'(time_irq_o), 64'd0);
    @(posedge clk_i);
    #1;
    req.valid = 1'b0;
    rst_i = 1'b0;
    model_reset();
    rd(32'h00); check("rst2_ctrl", 64'(g_rd), 64'd0);
    rd(32'h10); check("rst2_cmp_lo", 64'(g_rd), 64'hFFFF_FFFF);
    rd(32'h14);

    // Randomized bus traffic against the model
    for (int n = 0; n < 800; n++) begin
      idx  = 3'($urandom_range(0, 7));
      rv   = ($urandom_range(0, 7) != 0);
      rw   = 1'($urandom_range(0, 1));
      rs   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      rdat = $urandom;
      if (idx == 3'd1) rdat = $urandom_range(0, 3);
      if (idx == 3'd4 && $urandom_range(0, 1) == 1) rdat = m_mtime[31:0] + $urandom_range(0, 20);
      if (idx == 3'd5 && $urandom_range(0, 3) != 0) rdat = m_mtime[63:32];
      if (idx == 3'd3 && $urandom_range(0, 3) != 0) rdat = m_cmp[63:32];
      ra = {27'd0, idx, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 15) == 0) ra = ra | (32'h20 << $urandom_range(0, 26));
      step(rv, rw, ra, rdat, rs, g_rd, g_er);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
